// File: rtl/st7789_spi_monitor.sv
// Passive tap on the ST7789 4-wire serial bus: rebuilds bytes from SCK/SDA/DC and
// decodes CASET/RASET/RAMWR/RAMWRC/SWRESET into window registers and tagged pixels.
module st7789_spi_monitor #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 240,
  parameter int PIXEL_BYTES  = 3,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        LCD_SCK,
  input  logic        LCD_SDA,
  input  logic        LCD_DC,
  input  logic        LCD_RST,
  output logic [7:0]  BYTE_DATA,
  output logic        BYTE_DC,
  output logic        BYTE_VALID,
  output logic [7:0]  CMD_CODE,
  output logic        CMD_VALID,
  output logic [23:0] PIXEL_DATA,
  output logic [15:0] PIXEL_X,
  output logic [15:0] PIXEL_Y,
  output logic        PIXEL_VALID,
  output logic        FRAME_ERR
);

  localparam int              TO_W     = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_SAT   = TO_W'(IDLE_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [1:0]      PIX_LAST = 2'(PIXEL_BYTES - 1);
  localparam logic [15:0]     XE_RST   = 16'(WIDTH - 1);
  localparam logic [15:0]     YE_RST   = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_CASET, ST_RASET, ST_RAMWR, ST_IGNORE} state_t;

  function automatic logic [23:0] pack_pixel(input logic [15:0] acc, input logic [7:0] last);
    if (PIXEL_BYTES == 2) pack_pixel = {8'h00, acc[7:0], last};
    else                  pack_pixel = {acc, last};
  endfunction

  logic            r_sck_s1, r_sck_s2, r_sck_s3;
  logic            r_sda_s1, r_sda_s2;
  logic            r_dc_s1, r_dc_s2;
  logic            r_rst_s1, r_rst_s2;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_dc_lat;
  logic            r_done_p1;
  logic [TO_W-1:0] r_idle_cnt;
  state_t          r_state, w_state_nxt;
  logic [1:0]      r_par_idx, r_pix_idx;
  logic [15:0]     r_acc;
  logic [15:0]     r_xs, r_xe, r_ys, r_ye, r_x, r_y;
  logic            w_rise, w_lcd_rst, w_timeout;
  logic            w_cmd, w_data, w_pix_done;

  // Stage s1..s3: synchronizers; SCK gets a third flop for edge detection
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      {r_sck_s1, r_sck_s2, r_sck_s3} <= 3'b000;
      {r_sda_s1, r_sda_s2}           <= 2'b00;
      {r_dc_s1, r_dc_s2}             <= 2'b00;
      {r_rst_s1, r_rst_s2}           <= 2'b00;
    end else begin
      r_sck_s1 <= LCD_SCK;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_sda_s1 <= LCD_SDA;
      r_sda_s2 <= r_sda_s1;
      r_dc_s1  <= LCD_DC;
      r_dc_s2  <= r_dc_s1;
      r_rst_s1 <= LCD_RST;
      r_rst_s2 <= r_rst_s1;
    end
  end

  assign w_rise    = r_sck_s2 & ~r_sck_s3;
  assign w_lcd_rst = ~r_rst_s2;
  assign w_timeout = ~w_rise & (r_idle_cnt == TO_LAST);

  // Stage p1: bit assembly; p2: byte presented on BYTE_* outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_dc_lat   <= 1'b0;
      r_done_p1  <= 1'b0;
      r_idle_cnt <= '0;
      BYTE_DATA  <= 8'h00;
      BYTE_DC    <= 1'b0;
      BYTE_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else if (w_lcd_rst) begin
      r_bit_cnt  <= 3'd0;
      r_done_p1  <= 1'b0;
      r_idle_cnt <= '0;
      BYTE_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      r_done_p1  <= 1'b0;
      BYTE_VALID <= r_done_p1;
      FRAME_ERR  <= 1'b0;
      if (r_done_p1) begin
        BYTE_DATA <= r_shift;
        BYTE_DC   <= r_dc_lat;
      end
      if (w_rise) begin
        r_shift    <= {r_shift[6:0], r_sda_s2};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_idle_cnt <= '0;
        if (r_bit_cnt == 3'd7) begin
          r_dc_lat  <= r_dc_s2;
          r_done_p1 <= 1'b1;
        end
      end else begin
        // Saturating idle count so the timeout fires once per quiet period
        if (r_idle_cnt != TO_SAT) r_idle_cnt <= r_idle_cnt + TO_ONE;
        if (w_timeout) begin
          r_bit_cnt <= 3'd0;
          FRAME_ERR <= (r_bit_cnt != 3'd0);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd       = BYTE_VALID & ~BYTE_DC;
    w_data      = BYTE_VALID & BYTE_DC;
    w_pix_done  = w_data && (r_state == ST_RAMWR) && (r_pix_idx == PIX_LAST);
    if (w_cmd) begin
      case (BYTE_DATA)
        8'h2A:        w_state_nxt = ST_CASET;
        8'h2B:        w_state_nxt = ST_RASET;
        8'h2C, 8'h3C: w_state_nxt = ST_RAMWR;
        8'h01:        w_state_nxt = ST_IDLE;
        default:      w_state_nxt = ST_IGNORE;
      endcase
    end else if (w_data && (r_state == ST_CASET || r_state == ST_RASET) && r_par_idx == 2'd3) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)       r_state <= ST_IDLE;
    else if (w_lcd_rst) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Stage p3: command/window/pixel decode, one cycle behind BYTE_VALID
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_par_idx   <= 2'd0;
      r_pix_idx   <= 2'd0;
      r_acc       <= 16'h0000;
      r_xs        <= 16'h0000;
      r_xe        <= XE_RST;
      r_ys        <= 16'h0000;
      r_ye        <= YE_RST;
      r_x         <= 16'h0000;
      r_y         <= 16'h0000;
      CMD_CODE    <= 8'h00;
      CMD_VALID   <= 1'b0;
      PIXEL_DATA  <= 24'h000000;
      PIXEL_X     <= 16'h0000;
      PIXEL_Y     <= 16'h0000;
      PIXEL_VALID <= 1'b0;
    end else if (w_lcd_rst) begin
      r_par_idx   <= 2'd0;
      r_pix_idx   <= 2'd0;
      r_xs        <= 16'h0000;
      r_xe        <= XE_RST;
      r_ys        <= 16'h0000;
      r_ye        <= YE_RST;
      r_x         <= 16'h0000;
      r_y         <= 16'h0000;
      CMD_VALID   <= 1'b0;
      PIXEL_VALID <= 1'b0;
    end else begin
      CMD_VALID   <= w_cmd;
      PIXEL_VALID <= w_pix_done;
      if (w_cmd) begin
        CMD_CODE  <= BYTE_DATA;
        r_par_idx <= 2'd0;
        r_pix_idx <= 2'd0;
        if (BYTE_DATA == 8'h2C) begin
          r_x <= r_xs;
          r_y <= r_ys;
        end
        if (BYTE_DATA == 8'h01) begin
          r_xs <= 16'h0000;
          r_xe <= XE_RST;
          r_ys <= 16'h0000;
          r_ye <= YE_RST;
        end
      end else if (w_data) begin
        case (r_state)
          ST_CASET: begin
            r_par_idx <= r_par_idx + 2'd1;
            case (r_par_idx)
              2'd0:    r_xs[15:8] <= BYTE_DATA;
              2'd1:    r_xs[7:0]  <= BYTE_DATA;
              2'd2:    r_xe[15:8] <= BYTE_DATA;
              default: r_xe[7:0]  <= BYTE_DATA;
            endcase
          end
          ST_RASET: begin
            r_par_idx <= r_par_idx + 2'd1;
            case (r_par_idx)
              2'd0:    r_ys[15:8] <= BYTE_DATA;
              2'd1:    r_ys[7:0]  <= BYTE_DATA;
              2'd2:    r_ye[15:8] <= BYTE_DATA;
              default: r_ye[7:0]  <= BYTE_DATA;
            endcase
          end
          ST_RAMWR: begin
            r_acc <= {r_acc[7:0], BYTE_DATA};
            if (w_pix_done) begin
              r_pix_idx  <= 2'd0;
              PIXEL_DATA <= pack_pixel(r_acc, BYTE_DATA);
              PIXEL_X    <= r_x;
              PIXEL_Y    <= r_y;
              // Equality-only wrap: XS>XE simply counts through 0xFFFF
              if (r_x == r_xe) begin
                r_x <= r_xs;
                r_y <= (r_y == r_ye) ? r_ys : r_y + 16'd1;
              end else begin
                r_x <= r_x + 16'd1;
              end
            end else begin
              r_pix_idx <= r_pix_idx + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_st7789_spi_monitor.sv
// Directed bench for st7789_spi_monitor: byte latency, window decode, frame wrap,
// timeout, RAMWRC continuation, LCD_RST and RESET_N behaviour.
module tb_st7789_spi_monitor;

  localparam int TW = 8;
  localparam int TH = 4;
  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        LCD_SCK = 1'b0, LCD_SDA = 1'b0, LCD_DC = 1'b0, LCD_RST = 1'b1;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_DC, BYTE_VALID;
  logic [7:0]  CMD_CODE;
  logic        CMD_VALID;
  logic [23:0] PIXEL_DATA;
  logic [15:0] PIXEL_X, PIXEL_Y;
  logic        PIXEL_VALID, FRAME_ERR;

  st7789_spi_monitor #(.WIDTH(TW), .HEIGHT(TH), .PIXEL_BYTES(3), .IDLE_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LCD_SCK(LCD_SCK), .LCD_SDA(LCD_SDA), .LCD_DC(LCD_DC),
    .LCD_RST(LCD_RST), .BYTE_DATA(BYTE_DATA), .BYTE_DC(BYTE_DC), .BYTE_VALID(BYTE_VALID),
    .CMD_CODE(CMD_CODE), .CMD_VALID(CMD_VALID), .PIXEL_DATA(PIXEL_DATA), .PIXEL_X(PIXEL_X),
    .PIXEL_Y(PIXEL_Y), .PIXEL_VALID(PIXEL_VALID), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] d;
    logic [15:0] x;
    logic [15:0] y;
  } px_t;

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    logic        pix;
    logic [23:0] pd;
    logic [15:0] px;
    logic [15:0] py;
  } vec_t;

  px_t pix_q[$];
  int  n_byte = 0, n_cmd = 0, n_ferr = 0;
  int  n_chk = 0, n_err = 0;

  always @(negedge CLK) begin
    if (BYTE_VALID) n_byte <= n_byte + 1;
    if (CMD_VALID)  n_cmd  <= n_cmd + 1;
    if (FRAME_ERR)  n_ferr <= n_ferr + 1;
    if (PIXEL_VALID) pix_q.push_back('{PIXEL_DATA, PIXEL_X, PIXEL_Y});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_pix(input string nm, input logic [23:0] d, input logic [15:0] x,
                            input logic [15:0] y);
    px_t p;
    if (pix_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got no pixel, expected %0h at (%0d,%0d)", nm, d, x, y);
    end else begin
      p = pix_q.pop_front();
      chk({nm, "_data"}, 48'(p.d), 48'(d));
      chk({nm, "_xy"}, 48'({p.x, p.y}), 48'({x, y}));
    end
  endtask

  task automatic idle(input int n);
    LCD_SCK = 1'b0;
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic dc);
    LCD_SDA = b;
    LCD_DC  = dc;
    LCD_SCK = 1'b0;
    repeat (2) @(negedge CLK);
    LCD_SCK = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
  endtask

  vec_t vt [22];
  int   lat, b0, f0, c0;

  initial begin
    vt[0]  = '{1'b0, 8'h2A, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[1]  = '{1'b1, 8'h00, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[2]  = '{1'b1, 8'h0A, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[3]  = '{1'b1, 8'h00, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[4]  = '{1'b1, 8'h0B, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[5]  = '{1'b0, 8'h2B, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[6]  = '{1'b1, 8'h00, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[7]  = '{1'b1, 8'h14, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[8]  = '{1'b1, 8'h00, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[9]  = '{1'b1, 8'h14, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[10] = '{1'b0, 8'h2C, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[11] = '{1'b1, 8'h11, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[12] = '{1'b1, 8'h22, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[13] = '{1'b1, 8'h33, 1'b1, 24'h112233, 16'd10, 16'd20};
    vt[14] = '{1'b1, 8'h44, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[15] = '{1'b1, 8'h55, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[16] = '{1'b1, 8'h66, 1'b1, 24'h445566, 16'd11, 16'd20};
    vt[17] = '{1'b1, 8'h77, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[18] = '{1'b1, 8'h88, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[19] = '{1'b1, 8'h99, 1'b1, 24'h778899, 16'd10, 16'd20};
    vt[20] = '{1'b0, 8'h36, 1'b0, 24'h0, 16'd0, 16'd0};
    vt[21] = '{1'b1, 8'hAB, 1'b0, 24'h0, 16'd0, 16'd0};

    // Reset values
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_byte_data", 48'(BYTE_DATA), 48'h0);
    chk("rst_byte_dc", 48'(BYTE_DC), 48'h0);
    chk("rst_byte_valid", 48'(BYTE_VALID), 48'h0);
    chk("rst_cmd", 48'({CMD_CODE, CMD_VALID}), 48'h0);
    chk("rst_pixel", 48'({PIXEL_DATA, PIXEL_VALID}), 48'h0);
    chk("rst_pixel_xy", 48'({PIXEL_X, PIXEL_Y}), 48'h0);
    chk("rst_frame_err", 48'(FRAME_ERR), 48'h0);
    RESET_N = 1'b1;
    idle(5);

    // Single byte 0xA5 with DC=1 and latency measurement
    b0 = n_byte;
    for (int i = 7; i >= 1; i--) send_bit(1'(8'hA5 >> i), 1'b1);
    LCD_SDA = 1'b1;
    LCD_DC  = 1'b1;
    LCD_SCK = 1'b0;
    repeat (2) @(negedge CLK);
    LCD_SCK = 1'b1;
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (BYTE_VALID === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    chk("byte_latency", 48'(lat), 48'd3);
    @(negedge CLK);
    chk("byte_valid_width", 48'(BYTE_VALID), 48'h0);
    idle(4);
    chk("a5_data", 48'(BYTE_DATA), 48'hA5);
    chk("a5_dc", 48'(BYTE_DC), 48'h1);
    chk("a5_count", 48'(n_byte - b0), 48'd1);

    // Table: window setup, RAMWR with wrap, ignored command
    pix_q.delete();
    c0 = n_cmd;
    for (int i = 0; i < 22; i++) begin
      send_byte(vt[i].b, vt[i].dc);
      idle(4);
      chk("vec_byte", 48'({BYTE_DATA, BYTE_DC}), 48'({vt[i].b, vt[i].dc}));
      if (!vt[i].dc) chk("vec_cmd_code", 48'(CMD_CODE), 48'(vt[i].b));
      if (vt[i].pix) expect_pix("vec_pix", vt[i].pd, vt[i].px, vt[i].py);
      else chk("vec_no_pix", 48'(pix_q.size()), 48'd0);
    end
    chk("vec_cmd_count", 48'(n_cmd - c0), 48'd4);

    // Default window frame plus one extra pixel, back-to-back bytes
    send_byte(8'h01, 1'b0);
    send_byte(8'h2C, 1'b0);
    pix_q.delete();
    for (int i = 0; i <= TW * TH; i++) repeat (3) send_byte(8'(i), 1'b1);
    idle(8);
    chk("frame_count", 48'(pix_q.size()), 48'(TW * TH + 1));
    for (int i = 0; i <= TW * TH; i++) begin
      logic [7:0] v;
      v = 8'(i);
      expect_pix("frame_pix", {v, v, v}, 16'(i % TW), 16'((i / TW) % TH));
    end

    // Partial byte followed by idle timeout
    b0 = n_byte;
    f0 = n_ferr;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    idle(TO + 8);
    chk("to_frame_err", 48'(n_ferr - f0), 48'd1);
    chk("to_no_byte", 48'(n_byte - b0), 48'd0);
    send_byte(8'h5A, 1'b1);
    idle(4);
    chk("to_next_byte", 48'({BYTE_DATA, BYTE_DC}), 48'({8'h5A, 1'b1}));
    chk("to_next_count", 48'(n_byte - b0), 48'd1);
    chk("to_err_once", 48'(n_ferr - f0), 48'd1);

    // RAMWR, one pixel, partial pixel, then RAMWRC continues at next X
    pix_q.delete();
    send_byte(8'h2C, 1'b0);
    send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1); send_byte(8'hC3, 1'b1);
    send_byte(8'hD1, 1'b1); send_byte(8'hD2, 1'b1);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hE1, 1'b1); send_byte(8'hE2, 1'b1); send_byte(8'hE3, 1'b1);
    idle(8);
    chk("ramwrc_count", 48'(pix_q.size()), 48'd2);
    expect_pix("ramwrc_first", 24'hC1C2C3, 16'd0, 16'd0);
    expect_pix("ramwrc_cont", 24'hE1E2E3, 16'd1, 16'd0);

    // LCD_RST during RAMWR restores window and drops out of RAMWR
    pix_q.delete();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_byte(8'hF1, 1'b1); send_byte(8'hF2, 1'b1); send_byte(8'hF3, 1'b1);
    idle(8);
    expect_pix("lrst_before", 24'hF1F2F3, 16'd2, 16'd0);
    LCD_RST = 1'b0;
    idle(5);
    LCD_RST = 1'b1;
    idle(5);
    chk("lrst_hold", 48'({PIXEL_DATA, PIXEL_X}), 48'({24'hF1F2F3, 16'd2}));
    send_byte(8'h11, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h13, 1'b1);
    idle(8);
    chk("lrst_no_pix", 48'(pix_q.size()), 48'd0);
    send_byte(8'h2C, 1'b0);
    send_byte(8'h21, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h23, 1'b1);
    idle(8);
    expect_pix("lrst_after", 24'h212223, 16'd0, 16'd0);

    // RESET_N mid-pixel and mid-byte
    pix_q.delete();
    send_byte(8'h31, 1'b1); send_byte(8'h32, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    #1;
    RESET_N = 1'b0;
    @(negedge CLK);
    #1;
    chk("arst_pixel", 48'({PIXEL_DATA, PIXEL_VALID}), 48'h0);
    chk("arst_cmd", 48'(CMD_CODE), 48'h0);
    chk("arst_byte", 48'({BYTE_DATA, BYTE_VALID}), 48'h0);
    RESET_N = 1'b1;
    idle(10);
    chk("arst_no_pix", 48'(pix_q.size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/st7789_spi_monitor.md
# st7789_spi_monitor

Receive-side companion to the ST7789 display driver. It passively samples the 4-wire serial bus that drives the panel (LCD_SCK, LCD_SDA, LCD_DC, LCD_RST) and reassembles the traffic into bytes. It then decodes the ST7789 command stream into window registers and coordinate-tagged pixels. It sits on the FPGA next to the driver, tapping the same nets, and feeds ILA/VIO or a frame checker for loopback verification without a physical panel.

## Interface
- WIDTH, 240: default column count; XE reset value is WIDTH-1
- HEIGHT, 240: default row count; YE reset value is HEIGHT-1
- PIXEL_BYTES, 3: bytes per pixel in RAMWR data (legal values 2 or 3)
- IDLE_TIMEOUT, 64: CLK cycles without an SCK rising edge before the bit counter is cleared
- CLK  in  1  system clock (100 MHz)
- RESET_N  in  1  asynchronous, active-low reset
- LCD_SCK, LCD_SDA, LCD_DC, LCD_RST  in  1 each  tapped bus signals, asynchronous to CLK
- BYTE_DATA  out  8  last received byte
- BYTE_DC  out  1  DC level latched with bit 0 (0 = command, 1 = data)
- BYTE_VALID  out  1  one-cycle pulse per received byte
- CMD_CODE  out  8  last command byte
- CMD_VALID  out  1  one-cycle pulse per command byte
- PIXEL_DATA  out  24  assembled pixel, first byte in [23:16]; when PIXEL_BYTES=2, {8'h00, b0, b1}
- PIXEL_X, PIXEL_Y  out  16 each  coordinate of PIXEL_DATA
- PIXEL_VALID  out  1  one-cycle pulse per complete pixel
- FRAME_ERR  out  1  one-cycle pulse when a timeout discards a partial byte

## Operation
- Reset: all outputs 0. XS=0, XE=WIDTH-1, YS=0, YE=HEIGHT-1. Decoder state IDLE, bit and byte counters 0.
- Input capture: 2-flop synchronizer on all four inputs. An SCK rising edge is stage-2 high with stage-3 low. SDA and DC are taken from the matching stage-2 samples. MSB first. SCK frequency must be ≤ CLK/4.
- Bit counter 0..7: on the 8th edge, BYTE_DATA and BYTE_DC update, BYTE_VALID pulses, and the counter returns to 0.
- Idle timeout: after IDLE_TIMEOUT cycles with no edge, the bit counter clears. FRAME_ERR pulses only if the count was nonzero.
- LCD_RST low (synchronized) acts like RESET_N except that outputs hold their last values. It clears the counters, the window registers and the decoder state.
- Decoder states:
  - IDLE: waiting for a command byte.
  - CASET (0x2A): four parameter bytes load XS[15:8], XS[7:0], XE[15:8], XE[7:0], then IDLE.
  - RASET (0x2B): same order, loading YS and YE.
  - RAMWR (0x2C): X=XS, Y=YS, byte index 0. Data bytes accumulate; on the PIXEL_BYTES-th byte PIXEL_VALID pulses with the current X/Y.
  - RAMWRC (0x3C): same as RAMWR but continues from the current X/Y without reloading.
  - SWRESET (0x01): window returns to reset defaults, then IDLE.
  - Any other command: IGNORE; data bytes are discarded until the next command.
- After each pixel in RAMWR/RAMWRC:
  - if X==XE, then X=XS and Y increments;
  - if additionally Y==YE, then Y=YS (frame wrap).
- Any command byte aborts the current state. A partial pixel is discarded silently, and a partial CASET/RASET leaves the already-written bytes updated.
- Data bytes received in IDLE are ignored.
- XS>XE is not checked. X increments to 0xFFFF, then wraps to 0 and compares on equality only.

## Timing
- BYTE_VALID is asserted 3 CLK cycles after the CLK edge at which the 8th SCK rising edge is first captured by synchronizer stage 1.
- CMD_VALID and PIXEL_VALID are registered, one cycle after the BYTE_VALID that completes them. CMD_CODE, PIXEL_DATA and PIXEL_X/Y are stable from that pulse until the next one.
- Back-to-back bytes at SCK = CLK/4 are all captured; the minimum BYTE_VALID spacing is 32 cycles.
- Timeout and SCK edge in the same cycle: the edge wins and the timeout counter restarts.
- RESET_N asserted mid-byte or mid-pixel: immediate asynchronous clear, and no pulse is emitted.

## Test plan
- Single byte 0xA5 with DC=1 at SCK=CLK/4 -> one BYTE_VALID, BYTE_DATA=0xA5, BYTE_DC=1, 3-cycle latency measured.
- Sequence 0x2A + 00 0A 00 0B, 0x2B + 00 14 00 14, 0x2C + 3 pixels of 3 bytes (11 22 33, 44 55 66, 77 88 99) -> pixels at (10,20), (11,20) and the wrap to (10,20). PIXEL_DATA values are 0x112233, 0x445566, 0x778899.
- Default window, 240×240 RAMWR plus one extra pixel -> last pixel of the frame at (239,239), extra pixel at (0,0).
- 5 SCK edges then idle for IDLE_TIMEOUT cycles -> FRAME_ERR pulses once and no BYTE_VALID. The next full byte decodes correctly.
- RAMWR, 2 bytes of a pixel, then command 0x3C plus 3 bytes -> no pixel for the partial, and the next pixel is at the continued X/Y.
- LCD_RST pulse low during RAMWR, then data bytes -> no PIXEL_VALID until a new 0x2C, and the window is restored to defaults.
